// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Holds the fetch FSM states and the word/address bundle.
package fetch_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] pc;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid.sv
// Output register plus one-entry skid buffer towards decode.
// Words leave in arrival order; flush empties both entries.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  fetch_word_t in_word,
  output logic        in_stall,
  output logic        out_valid,
  output fetch_word_t out_word,
  input  logic        out_stall
);

  fetch_word_t skid_word;
  logic        skid_valid;
  logic        slot_free;

  assign slot_free = !out_valid || !out_stall;
  assign in_stall  = !slot_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_word   <= '0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (slot_free) begin
      if (skid_valid) begin
        out_word   <= skid_word;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_word <= in_word;
      end
    end else if (in_valid) begin
      // decode is blocked: park the word so the read can retire
      skid_word  <= in_word;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues zero-latency reads for the PC and
// hands words to decode through a skid-buffered output slot.
module instr_fetch
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_addr,
  input  logic              pc_active,
  output logic              pc_stall,
  input  logic              flush,
  input  logic              decode_stall,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [WORD_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [WORD_W-1:0] mem_readdata
);

  fetch_state_e      state, state_n;
  logic [WORD_W-1:0] req_addr;
  logic              req_load;
  logic              wr_valid;
  logic              slot_stall;
  fetch_word_t       rd_word;
  fetch_word_t       out_word;

  assign mem_read    = (state == REQ) || (state == DROP);
  assign mem_address = mem_read ? req_addr : '0;
  assign rd_word     = '{word: mem_readdata, pc: req_addr};
  assign instr       = out_word.word;
  assign instr_pc    = out_word.pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_addr <= '0;
    end else begin
      state <= state_n;
      if (req_load) req_addr <= pc_addr;
    end
  end

  always_comb begin
    state_n  = state;
    pc_stall = 1'b0;
    req_load = 1'b0;
    wr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush && pc_active) begin
          req_load = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          pc_stall = 1'b1;
          state_n  = mem_waitrequest ? DROP : IDLE;
        end else if (mem_waitrequest) begin
          pc_stall = 1'b1;
        end else if (!slot_stall) begin
          wr_valid = 1'b1;
          if (pc_active) req_load = 1'b1;
          else           state_n  = IDLE;
        end else begin
          wr_valid = 1'b1;
          pc_stall = 1'b1;
          state_n  = HOLD;
        end
      end
      DROP: begin
        pc_stall = 1'b1;
        if (!mem_waitrequest) state_n = IDLE;
      end
      HOLD: begin
        pc_stall = 1'b1;
        if (flush || !slot_stall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (wr_valid),
    .in_word   (rd_word),
    .in_stall  (slot_stall),
    .out_valid (instr_valid),
    .out_word  (out_word),
    .out_stall (decode_stall)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// Memory returns address XOR a fixed key.
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        pc_active = 1'b0;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic        decode_stall = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] seen_q[$];

  always #5 clk = ~clk;

  assign mem_readdata = mem_address ^ KEY;

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc_addr         (pc_addr),
    .pc_active       (pc_active),
    .pc_stall        (pc_stall),
    .flush           (flush),
    .decode_stall    (decode_stall),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata)
  );

  always @(posedge clk)
    if (rst && instr_valid && !decode_stall && !flush)
      seen_q.push_back(instr_pc);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    pc_active = 1'b1;
    pc_addr   = 32'h1111_2220;
    #2;
    checks++; if (mem_read !== 1'b0) begin failures++;
      $display("FAIL rst_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_address !== 32'h0) begin failures++;
      $display("FAIL rst_mem_address: got %h want 0", mem_address); end
    checks++; if (pc_stall !== 1'b0) begin failures++;
      $display("FAIL rst_pc_stall: got %b want 0", pc_stall); end
    checks++; if (instr_valid !== 1'b0) begin failures++;
      $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++;
      $display("FAIL rst_instr: got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++;
      $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    tick;
    tick;
    checks++; if (mem_read !== 1'b0) begin failures++;
      $display("FAIL rst_hold_read: got %b want 0", mem_read); end
    pc_active = 1'b0;
    rst = 1'b1;
    tick;
    checks++; if (mem_read !== 1'b0) begin failures++;
      $display("FAIL rst_idle_read: got %b want 0", mem_read); end
  endtask

  task automatic test_stream;
    logic [31:0] base;
    logic [31:0] e;
    base = 32'hBFC0_0000;
    mem_waitrequest = 1'b0;
    decode_stall = 1'b0;
    pc_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_addr = base + 32'(4 * i);
      #1;
      checks++; if (pc_stall !== 1'b0) begin failures++;
        $display("FAIL stream_pc_stall: got %b want 0", pc_stall); end
      tick;
      e = base + 32'(4 * i);
      checks++; if (mem_address !== e || mem_read !== 1'b1) begin
        failures++;
        $display("FAIL stream_addr: got %h want %h", mem_address, e);
      end
      if (i == 0) begin
        checks++; if (instr_valid !== 1'b0) begin failures++;
          $display("FAIL stream_early_valid: got %b want 0", instr_valid); end
      end else begin
        e = base + 32'(4 * (i - 1));
        checks++; if (instr_valid !== 1'b1 || instr_pc !== e) begin
          failures++;
          $display("FAIL stream_pc: got %h want %h", instr_pc, e);
        end
      end
    end
    pc_active = 1'b0;
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hBFC0_0008) begin
      failures++;
      $display("FAIL stream_last_pc: got %h want bfc00008", instr_pc);
    end
    checks++; if (instr !== (32'hBFC0_0008 ^ KEY)) begin failures++;
      $display("FAIL stream_last_instr: got %h want %h",
               instr, 32'hBFC0_0008 ^ KEY); end
    checks++; if (mem_read !== 1'b0) begin failures++;
      $display("FAIL stream_idle_read: got %b want 0", mem_read); end
    tick;
    checks++; if (instr_valid !== 1'b0) begin failures++;
      $display("FAIL stream_drain: got %b want 0", instr_valid); end
  endtask

  task automatic test_wait;
    pc_addr = 32'hBFC0_0000;
    pc_active = 1'b1;
    mem_waitrequest = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'hBFC0_0000)
      begin
        failures++;
        $display("FAIL wait_addr: got %h want bfc00000", mem_address);
      end
      checks++; if (pc_stall !== 1'b1) begin failures++;
        $display("FAIL wait_pc_stall: got %b want 1", pc_stall); end
      checks++; if (instr_valid !== 1'b0) begin failures++;
        $display("FAIL wait_valid: got %b want 0", instr_valid); end
      if (k < 2) tick;
    end
    mem_waitrequest = 1'b0;
    pc_active = 1'b0;
    #1;
    checks++; if (pc_stall !== 1'b0) begin failures++;
      $display("FAIL wait_release_stall: got %b want 0", pc_stall); end
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hBFC0_0000) begin
      failures++;
      $display("FAIL wait_instr_pc: got %h want bfc00000", instr_pc);
    end
    checks++; if (instr !== (32'hBFC0_0000 ^ KEY)) begin failures++;
      $display("FAIL wait_instr: got %h want %h",
               instr, 32'hBFC0_0000 ^ KEY); end
    tick;
  endtask

  task automatic test_backpressure;
    logic [31:0] b0;
    logic [31:0] e;
    b0 = 32'h0000_1000;
    seen_q.delete();
    mem_waitrequest = 1'b0;
    decode_stall = 1'b0;
    pc_active = 1'b1;
    pc_addr = b0;
    tick;
    pc_addr = b0 + 32'd4;
    tick;
    pc_addr = b0 + 32'd8;
    decode_stall = 1'b1;
    #1;
    checks++; if (pc_stall !== 1'b1 || instr_pc !== b0) begin failures++;
      $display("FAIL bp_fill: got stall=%b pc=%h want 1 %h",
               pc_stall, instr_pc, b0); end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (mem_read !== 1'b0 || pc_stall !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold: got read=%b stall=%b want 0 1",
                 mem_read, pc_stall);
      end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== b0) begin
        failures++;
        $display("FAIL bp_stable: got %h want %h", instr_pc, b0);
      end
    end
    decode_stall = 1'b0;
    #1;
    checks++; if (pc_stall !== 1'b1) begin failures++;
      $display("FAIL bp_release_stall: got %b want 1", pc_stall); end
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== b0 + 32'd4) begin
      failures++;
      $display("FAIL bp_skid_out: got %h want %h", instr_pc, b0 + 32'd4);
    end
    #1;
    checks++; if (pc_stall !== 1'b0) begin failures++;
      $display("FAIL bp_idle_stall: got %b want 0", pc_stall); end
    tick;
    checks++; if (mem_address !== b0 + 32'd8 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_refetch: got %h want %h", mem_address, b0 + 32'd8);
    end
    pc_active = 1'b0;
    tick;
    checks++; if (instr_pc !== b0 + 32'd8 ||
                  instr !== ((b0 + 32'd8) ^ KEY)) begin
      failures++;
      $display("FAIL bp_last: got %h want %h", instr_pc, b0 + 32'd8);
    end
    tick;
    checks++; if (seen_q.size() != 3) begin failures++;
      $display("FAIL bp_count: got %0d want 3", seen_q.size()); end
    for (int i = 0; i < seen_q.size() && i < 3; i++) begin
      e = b0 + 32'(4 * i);
      checks++; if (seen_q[i] !== e) begin failures++;
        $display("FAIL bp_order: got %h want %h", seen_q[i], e); end
    end
  endtask

  task automatic test_flush_wait;
    pc_addr = 32'h2000_0000;
    pc_active = 1'b1;
    mem_waitrequest = 1'b1;
    tick;
    flush = 1'b1;
    pc_addr = 32'h8000_0043;
    tick;
    flush = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h2000_0000) begin
      failures++;
      $display("FAIL drop_addr: got %h want 20000000", mem_address);
    end
    checks++; if (pc_stall !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_stall: got stall=%b valid=%b want 1 0",
               pc_stall, instr_valid);
    end
    tick;
    checks++; if (mem_read !== 1'b1) begin failures++;
      $display("FAIL drop_read_held: got %b want 1", mem_read); end
    mem_waitrequest = 1'b0;
    #1;
    checks++; if (pc_stall !== 1'b1) begin failures++;
      $display("FAIL drop_done_stall: got %b want 1", pc_stall); end
    tick;
    checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL drop_discard: got valid=%b read=%b want 0 0",
               instr_valid, mem_read);
    end
    tick;
    checks++; if (mem_address !== 32'h8000_0043) begin failures++;
      $display("FAIL drop_new_pc: got %h want 80000043", mem_address); end
    pc_active = 1'b0;
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8000_0043 ||
                  instr !== (32'h8000_0043 ^ KEY)) begin
      failures++;
      $display("FAIL drop_target: got %h want 80000043", instr_pc);
    end
    tick;
  endtask

  task automatic test_flush_hold;
    mem_waitrequest = 1'b0;
    decode_stall = 1'b0;
    pc_active = 1'b1;
    pc_addr = 32'h3000_0000;
    tick;
    pc_addr = 32'h3000_0004;
    tick;
    pc_addr = 32'h3000_0008;
    decode_stall = 1'b1;
    tick;
    checks++; if (pc_stall !== 1'b1 || mem_read !== 1'b0) begin failures++;
      $display("FAIL fh_hold: got stall=%b read=%b want 1 0",
               pc_stall, mem_read); end
    flush = 1'b1;
    pc_active = 1'b0;
    tick;
    flush = 1'b0;
    decode_stall = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL fh_clear: got valid=%b read=%b want 0 0",
               instr_valid, mem_read);
    end
    tick;
    checks++; if (instr_valid !== 1'b0) begin failures++;
      $display("FAIL fh_skid_gone: got %b want 0", instr_valid); end
    pc_addr = 32'h4000_0000;
    pc_active = 1'b1;
    tick;
    flush = 1'b1;
    pc_active = 1'b0;
    tick;
    flush = 1'b0;
    checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL fh_req_flush: got valid=%b read=%b want 0 0",
               instr_valid, mem_read);
    end
    tick;
    checks++; if (instr_valid !== 1'b0) begin failures++;
      $display("FAIL fh_req_discard: got %b want 0", instr_valid); end
  endtask

  task automatic test_reset_mid;
    pc_addr = 32'h5000_0000;
    pc_active = 1'b1;
    mem_waitrequest = 1'b1;
    tick;
    checks++; if (mem_read !== 1'b1) begin failures++;
      $display("FAIL rm_pre_read: got %b want 1", mem_read); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_address !== 32'h0) begin
      failures++;
      $display("FAIL rm_read: got read=%b addr=%h want 0 0",
               mem_read, mem_address);
    end
    checks++; if (pc_stall !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_flags: got stall=%b valid=%b want 0 0",
               pc_stall, instr_valid);
    end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++;
      $display("FAIL rm_regs: got %h %h want 0 0", instr, instr_pc); end
    tick;
    rst = 1'b1;
    pc_addr = 32'h6000_0000;
    mem_waitrequest = 1'b0;
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h6000_0000) begin
      failures++;
      $display("FAIL rm_resume: got %h want 60000000", mem_address);
    end
    pc_active = 1'b0;
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h6000_0000) begin
      failures++;
      $display("FAIL rm_word: got %h want 60000000", instr_pc);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_wait;
    test_backpressure;
    test_flush_wait;
    test_flush_hold;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have a single clock: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have rst  in  1; reset is asynchronous and active-low (rst=0 resets).
REQ-003 SHALL have pc_addr  in  32  fetch address from the program counter; valid when pc_active=1.
REQ-004 SHALL have pc_active  in  1  program counter running; 0 means no fetch is issued.
REQ-005 SHALL have pc_stall  out  1  1 = pc_addr not accepted this cycle; the PC holds.
REQ-006 SHALL have flush  in  1  jump/branch redirect; discards all in-flight and buffered fetches.
REQ-007 SHALL have decode_stall  in  1  1 = decode cannot accept instr this cycle.
REQ-008 SHALL have instr  out  32, instr_pc  out  32, instr_valid  out  1: fetched word, its address, and its valid flag.
REQ-009 SHALL have a memory read port: mem_address  out  32, mem_read  out  1, mem_waitrequest  in  1, mem_readdata  in  32.

Function
REQ-010 SHALL implement four states: IDLE, REQ, DROP, HOLD.
REQ-011 SHALL, in IDLE with pc_active=1 and flush=0, latch pc_addr into req_addr, drive pc_stall=0, and move to REQ.
REQ-012 SHALL, in IDLE with pc_active=0, drive pc_stall=0 and mem_read=0.
REQ-013 SHALL drive mem_read=1 and mem_address=req_addr in REQ and DROP, holding both stable while mem_waitrequest=1.
REQ-014 SHALL treat mem_readdata as valid only in the cycle where mem_read=1 and mem_waitrequest=0 (zero-latency read).
REQ-015 SHALL, in REQ with mem_waitrequest=1, drive pc_stall=1.
REQ-016 SHALL define the output slot as free when instr_valid=0 or decode_stall=0.
REQ-017 SHALL, on REQ completion with flush=0 and the slot free, load instr, instr_pc and instr_valid from mem_readdata, req_addr and 1 on the next edge.
REQ-018 SHALL, on that same completion with pc_active=1, accept pc_addr (pc_stall=0) and remain in REQ (back-to-back, one instruction per cycle when memory never waits); with pc_active=0 it SHALL go to IDLE.
REQ-019 SHALL, on REQ completion with the slot not free, capture the word into a one-entry skid register, drive pc_stall=1, and go to HOLD.
REQ-020 SHALL, in HOLD, drive pc_stall=1 and mem_read=0; when the slot frees, move the skid entry into the output registers and go to IDLE.
REQ-021 SHALL, on flush=1 in REQ with mem_waitrequest=1, go to DROP and keep the read asserted.
REQ-022 SHALL, in DROP, discard the read data on completion and go to IDLE; pc_stall=1 throughout DROP.
REQ-023 SHALL, on flush=1 in REQ with mem_waitrequest=0, discard the data and go to IDLE.
REQ-024 SHALL, on any flush=1, clear instr_valid and the skid entry on the next edge; from HOLD it SHALL go to IDLE.
REQ-025 SHALL give flush priority over decode_stall and pc_active in the same cycle.
REQ-026 SHALL never present more than two fetched words at once (output register plus skid), and SHALL never reorder them.
REQ-027 SHALL hold instr and instr_pc stable while instr_valid=1 and decode_stall=1.
REQ-028 SHALL apply no arithmetic to addresses; req_addr is a pass-through of pc_addr (all 32 bits, no alignment check).

Reset
REQ-029 SHALL, while rst=0, force state=IDLE, mem_read=0, mem_address=0, pc_stall=0, instr_valid=0, instr=0, instr_pc=0, and clear the skid entry.
REQ-030 SHALL drop mem_read immediately on rst assertion mid-transaction; the outstanding read is abandoned and not reissued.
REQ-031 SHALL begin fetching on the first rising edge after rst deasserts at which pc_active=1.

Structure
REQ-032 SHALL place the state enum and a WORD_W=32 constant in a shared package, fetch_pkg.
REQ-033 SHALL implement the output register plus skid entry as one sub-module, fetch_skid, with a valid/stall interface and a flush input.

Verification
REQ-034 Zero-wait stream: pc_addr 0xBFC00000, +4, +8 and waitrequest=0 -> instr_valid on cycles 2, 3 and 4, instr_pc in order, pc_stall=0 throughout.
REQ-035 Wait states: waitrequest=1 for 3 cycles on 0xBFC00000 -> mem_address stable, pc_stall=1 for 3 cycles, then instr=readdata and instr_pc=0xBFC00000.
REQ-036 Backpressure: decode_stall=1 for 4 cycles during streaming -> skid fills, HOLD entered, pc_stall=1, no word lost or duplicated after release.
REQ-037 Flush during wait: flush=1 while waitrequest=1 -> DROP entered, mem_read held until waitrequest=0, data discarded, instr_valid=0, next fetch uses the new pc_addr.
REQ-038 Reset mid-read: rst=0 while in REQ -> mem_read=0 and all outputs 0 immediately; after release, fetch resumes from pc_addr.
